// File: rtl/shifto_rx_pkg.sv
// rtl/shifto_rx_pkg.sv - shared state encoding and SD SPI constants for the MISO receive path
package shifto_rx_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_HUNT  = 2'd1,
        ST_SHIFT = 2'd2
    } state_t;

    // The SD card signals the beginning of a response or data token with a low bit
    localparam logic SD_START_BIT = 1'b0;

    // Default NCR window, in sclk rising edges
    localparam int NCR_MAX_DEFAULT = 64;

endpackage

// File: rtl/spi_edge_det.sv
// rtl/spi_edge_det.sv - sclk edge detector gated by active-low chip select
module spi_edge_det (
    input  logic clk,
    input  logic reset,
    input  logic sclk,
    input  logic cs,
    output logic rise,
    output logic fall
);

    logic sclk_q;

    // Delay sclk by one clk so its transitions can be seen as single-cycle strobes
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sclk_q <= 1'b0;
        end else begin
            sclk_q <= sclk;
        end
    end

    assign rise = sclk & ~sclk_q & ~cs;
    assign fall = ~sclk & sclk_q & ~cs;

endmodule

// File: rtl/shifto_rx.sv
// rtl/shifto_rx.sv - SD SPI MISO deserialiser with start-bit hunt and NCR timeout
module shifto_rx
    import shifto_rx_pkg::*;
#(
    parameter int N       = 8,
    parameter int NCR_MAX = NCR_MAX_DEFAULT
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         sclk,
    input  logic         cs,
    input  logic         miso,
    input  logic         start,
    input  logic         hunt,
    output logic [N-1:0] data_out,
    output logic         valid,
    output logic         timeout,
    output logic         busy
);

    localparam int BW = $clog2(N);
    localparam int EW = $clog2(NCR_MAX);
    localparam logic [BW-1:0] BIT_LAST  = BW'(N - 1);
    localparam logic [EW-1:0] EDGE_LAST = EW'(NCR_MAX - 1);

    logic          rise;
    logic          edge_fall_unused;
    state_t        state;
    logic [N-1:0]  shreg;
    logic [BW-1:0] bit_cnt;
    logic [EW-1:0] edge_cnt;

    spi_edge_det u_edge_det (
        .clk   (clk),
        .reset (reset),
        .sclk  (sclk),
        .cs    (cs),
        .rise  (rise),
        .fall  (edge_fall_unused)
    );

    // Capture FSM: hunt for the start bit or shift raw bits, MSB first, on each sclk rise
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= ST_IDLE;
            shreg    <= '0;
            bit_cnt  <= '0;
            edge_cnt <= '0;
            data_out <= {N{1'b1}};
            valid    <= 1'b0;
            timeout  <= 1'b0;
            busy     <= 1'b0;
        end else begin
            valid   <= 1'b0;
            timeout <= 1'b0;
            case (state)
                ST_IDLE: begin
                    // A rise coinciding with start is deliberately not sampled
                    if (start) begin
                        state    <= hunt ? ST_HUNT : ST_SHIFT;
                        bit_cnt  <= '0;
                        edge_cnt <= '0;
                        busy     <= 1'b1;
                    end
                end
                ST_HUNT: begin
                    if (cs) begin
                        state <= ST_IDLE;
                        busy  <= 1'b0;
                    end else if (rise) begin
                        if (miso == SD_START_BIT) begin
                            // The start bit itself becomes data bit N-1
                            shreg   <= {shreg[N-2:0], SD_START_BIT};
                            bit_cnt <= BW'(1);
                            state   <= ST_SHIFT;
                        end else if (edge_cnt == EDGE_LAST) begin
                            timeout <= 1'b1;
                            busy    <= 1'b0;
                            state   <= ST_IDLE;
                        end else begin
                            edge_cnt <= edge_cnt + EW'(1);
                        end
                    end
                end
                ST_SHIFT: begin
                    if (cs) begin
                        state <= ST_IDLE;
                        busy  <= 1'b0;
                    end else if (rise) begin
                        shreg <= {shreg[N-2:0], miso};
                        if (bit_cnt == BIT_LAST) begin
                            data_out <= {shreg[N-2:0], miso};
                            valid    <= 1'b1;
                            busy     <= 1'b0;
                            state    <= ST_IDLE;
                        end else begin
                            bit_cnt <= bit_cnt + BW'(1);
                        end
                    end
                end
                default: begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_shifto_rx.sv
// tb/tb_shifto_rx.sv - self-checking bench for shifto_rx at N=8 and N=16
module tb_shifto_rx;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        sclk = 1'b0;
    logic        cs = 1'b0;
    logic        miso = 1'b1;
    logic        start8 = 1'b0;
    logic        start16 = 1'b0;
    logic        hunt = 1'b0;
    logic [7:0]  d8;
    logic [15:0] d16;
    logic        v8, t8, b8, v16, t16, b16;

    int compared = 0;
    int mismatched = 0;
    int vcnt8 = 0, tcnt8 = 0, vcnt16 = 0, tcnt16 = 0;

    shifto_rx #(.N(8), .NCR_MAX(64)) dut8 (
        .clk(clk), .reset(reset), .sclk(sclk), .cs(cs), .miso(miso),
        .start(start8), .hunt(hunt), .data_out(d8), .valid(v8),
        .timeout(t8), .busy(b8)
    );

    shifto_rx #(.N(16), .NCR_MAX(64)) dut16 (
        .clk(clk), .reset(reset), .sclk(sclk), .cs(cs), .miso(miso),
        .start(start16), .hunt(hunt), .data_out(d16), .valid(v16),
        .timeout(t16), .busy(b16)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          phase;
        int          bits;
        int          edges;
        int          word;
        logic [15:0] data;
        bit          valid;
        bit          timeout;
        bit          busy;
        bit          sclk_prev;
    } mdl_t;

    mdl_t m8, m16;

    function automatic mdl_t mreset(int n);
        mdl_t m;
        m.phase = 0; m.bits = 0; m.edges = 0; m.word = 0;
        m.data = 16'((1 << n) - 1);
        m.valid = 0; m.timeout = 0; m.busy = 0; m.sclk_prev = 0;
        return m;
    endfunction

    // Transaction-level view: phase 0 idle, 1 waiting for start bit, 2 collecting bits
    function automatic mdl_t mstep(mdl_t mi, int n, int ncr, bit st, bit hu,
                                   bit sc, bit c, bit mo);
        mdl_t m = mi;
        bit r = sc && !m.sclk_prev && !c;
        m.valid = 0;
        m.timeout = 0;
        if (m.phase == 0) begin
            if (st) begin
                m.phase = hu ? 1 : 2;
                m.bits = 0; m.edges = 0; m.word = 0; m.busy = 1;
            end
        end else if (c) begin
            m.phase = 0; m.busy = 0;
        end else if (r) begin
            if (m.phase == 1) begin
                m.edges++;
                if (mo == 1'b0) begin
                    m.word = 0; m.bits = 1; m.phase = 2;
                end else if (m.edges == ncr) begin
                    m.timeout = 1; m.busy = 0; m.phase = 0;
                end
            end else begin
                m.word = m.word * 2 + int'(mo);
                m.bits++;
                if (m.bits == n) begin
                    m.data = 16'(m.word);
                    m.valid = 1; m.busy = 0; m.phase = 0;
                end
            end
        end
        m.sclk_prev = sc;
        return m;
    endfunction

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Advance the model on each clk edge and compare every output one step later
    always @(posedge clk) begin
        if (reset) begin
            m8 = mreset(8);
            m16 = mreset(16);
        end else begin
            m8 = mstep(m8, 8, 64, start8, hunt, sclk, cs, miso);
            m16 = mstep(m16, 16, 64, start16, hunt, sclk, cs, miso);
        end
        #1;
        check("cyc_data8", 32'(d8), 32'(m8.data[7:0]));
        check("cyc_valid8", 32'(v8), 32'(m8.valid));
        check("cyc_timeout8", 32'(t8), 32'(m8.timeout));
        check("cyc_busy8", 32'(b8), 32'(m8.busy));
        check("cyc_data16", 32'(d16), 32'(m16.data));
        check("cyc_valid16", 32'(v16), 32'(m16.valid));
        check("cyc_timeout16", 32'(t16), 32'(m16.timeout));
        check("cyc_busy16", 32'(b16), 32'(m16.busy));
        if (v8) vcnt8++;
        if (t8) tcnt8++;
        if (v16) vcnt16++;
        if (t16) tcnt16++;
    end

    task automatic tick(int k);
        repeat (k) @(negedge clk);
    endtask

    task automatic bit_out(bit b);
        sclk = 1'b0;
        miso = b;
        @(negedge clk);
        sclk = 1'b1;
        @(negedge clk);
        @(negedge clk);
    endtask

    task automatic send(int val, int nb);
        for (int i = nb - 1; i >= 0; i--) bit_out(((val >> i) & 1) == 1);
        sclk = 1'b0;
        @(negedge clk);
    endtask

    task automatic go(bit h, bit wide);
        hunt = h;
        if (wide) start16 = 1'b1; else start8 = 1'b1;
        @(negedge clk);
        start8 = 1'b0;
        start16 = 1'b0;
    endtask

    initial begin
        @(negedge clk);
        reset = 1'b1;
        tick(2);
        check("rst_data8", 32'(d8), 32'h0000_00FF);
        check("rst_busy8", 32'(b8), 32'h0);
        check("rst_valid8", 32'(v8), 32'h0);
        check("rst_timeout8", 32'(t8), 32'h0);
        check("rst_data16", 32'(d16), 32'h0000_FFFF);
        reset = 1'b0;
        tick(2);

        // NCR timeout: 64 high bits while hunting
        go(1'b1, 1'b0);
        for (int i = 0; i < 64; i++) bit_out(1'b1);
        sclk = 1'b0;
        tick(3);
        check("to_count", 32'(tcnt8), 32'd1);
        check("to_novalid", 32'(vcnt8), 32'd0);
        check("to_data", 32'(d8), 32'h0000_00FF);
        check("to_busy", 32'(b8), 32'h0);

        // Raw capture of 0xA5
        go(1'b0, 1'b0);
        send(32'hA5, 8);
        tick(3);
        check("raw_data", 32'(d8), 32'h0000_00A5);
        check("raw_vcnt", 32'(vcnt8), 32'd1);

        // Hunt: five idle-high edges, then 0x01 whose MSB is the start bit
        go(1'b1, 1'b0);
        for (int i = 0; i < 5; i++) bit_out(1'b1);
        send(32'h01, 8);
        tick(3);
        check("hunt_data", 32'(d8), 32'h0000_0001);
        check("hunt_vcnt", 32'(vcnt8), 32'd2);
        check("hunt_tcnt", 32'(tcnt8), 32'd1);

        // Abort after three bits, then a clean capture of 0x3C
        go(1'b0, 1'b0);
        send(32'h5, 3);
        cs = 1'b1;
        tick(2);
        check("abort_busy", 32'(b8), 32'h0);
        cs = 1'b0;
        tick(2);
        check("abort_vcnt", 32'(vcnt8), 32'd2);
        check("abort_data", 32'(d8), 32'h0000_0001);
        go(1'b0, 1'b0);
        send(32'h3C, 8);
        tick(3);
        check("post_abort_data", 32'(d8), 32'h0000_003C);

        // Start while busy is ignored: 2 bits, stray start, 6 bits -> 0xA6
        go(1'b0, 1'b0);
        send(32'h2, 2);
        start8 = 1'b1;
        @(negedge clk);
        start8 = 1'b0;
        send(32'h26, 6);
        tick(3);
        check("busy_start_data", 32'(d8), 32'h0000_00A6);
        check("busy_start_vcnt", 32'(vcnt8), 32'd4);

        // Start in the cycle the last bit is sampled is ignored
        go(1'b0, 1'b0);
        for (int i = 7; i >= 1; i--) bit_out(((32'h5A >> i) & 1) == 1);
        sclk = 1'b0;
        miso = 1'b0;
        @(negedge clk);
        sclk = 1'b1;
        start8 = 1'b1;
        @(negedge clk);
        start8 = 1'b0;
        check("b2b_ignored_busy", 32'(b8), 32'h0);
        check("b2b_data", 32'(d8), 32'h0000_005A);
        sclk = 1'b0;
        tick(2);

        // Start with a simultaneous rise: that rise is not sampled
        start8 = 1'b1;
        hunt = 1'b0;
        sclk = 1'b1;
        miso = 1'b0;
        @(negedge clk);
        start8 = 1'b0;
        check("same_cycle_busy", 32'(b8), 32'h1);
        @(negedge clk);
        send(32'hC3, 8);
        tick(3);
        check("same_cycle_data", 32'(d8), 32'h0000_00C3);

        // Reset in the middle of a shift
        go(1'b0, 1'b0);
        send(32'hC, 4);
        #2 reset = 1'b1;
        #1;
        check("midrst_data", 32'(d8), 32'h0000_00FF);
        check("midrst_busy", 32'(b8), 32'h0);
        check("midrst_valid", 32'(v8), 32'h0);
        @(negedge clk);
        reset = 1'b0;
        tick(2);

        // Wide build: raw 16-bit capture
        go(1'b0, 1'b1);
        send(32'hBEEF, 16);
        tick(3);
        check("wide_data", 32'(d16), 32'h0000_BEEF);
        check("wide_vcnt", 32'(vcnt16), 32'd1);
        check("wide_tcnt", 32'(tcnt16), 32'd0);
        check("wide_narrow_idle", 32'(d8), 32'h0000_00FF);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
